limiter_pwr_seq: RTL and testbench

LIMITER_PWR_SEQ -- requirements
Module: limiter_pwr_seq

---
 rtl/limiter_pwr_seq.sv | 160 ++++++++++++++++
 tb/tb_limiter_pwr_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/limiter_pwr_seq.sv
// Limiter power sequencer: staged bias -> core -> output enable ramp with abortable
// power-up, a fixed-order power-down and a small CPU register window (SETTLE, STATUS).
module limiter_pwr_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic              pd_req,
  output logic              bias_en,
  output logic              lim_en,
  output logic              out_en,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_BIAS_UP = 3'd1,
    S_LIM_UP  = 3'd2,
    S_ON      = 3'd3,
    S_LIM_DN  = 3'd4,
    S_BIAS_DN = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] settle_q;
  logic [CNT_W-1:0] dur_m1;
  logic             bias_d, lim_d, out_d, done_d;
  logic             busy;
  logic [6:0]       status;
  logic             unused_wdata;

  // Only the low CNT_W bits of wdata are stored.
  assign unused_wdata = ^wdata;

  // Stage length is max(SETTLE,1); the counter runs D-1 down to 0.
  assign dur_m1 = (settle_q == '0) ? '0 : settle_q - CNT_W'(1);

  assign busy = (state_q == S_BIAS_UP) || (state_q == S_LIM_UP) ||
                (state_q == S_LIM_DN)  || (state_q == S_BIAS_DN);
  assign status    = {state_q, busy, out_en, lim_en, bias_en};
  assign dbg_state = state_q;

  // State register and registered sequencer outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      bias_en <= 1'b0;
      lim_en  <= 1'b0;
      out_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bias_en <= bias_d;
      lim_en  <= lim_d;
      out_en  <= out_d;
      done    <= done_d;
    end
  end

  // Next-state: pd_req aborts the up-ramp; the down-ramp always runs to OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (!pd_req) begin
          state_d = S_BIAS_UP;
          cnt_d   = dur_m1;
        end
      end
      S_BIAS_UP: begin
        if (pd_req) begin
          state_d = S_BIAS_DN;
          cnt_d   = dur_m1;
        end else if (cnt_q == '0) begin
          state_d = S_LIM_UP;
          cnt_d   = dur_m1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LIM_UP: begin
        if (pd_req) begin
          state_d = S_LIM_DN;
          cnt_d   = dur_m1;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ON: begin
        if (pd_req) begin
          state_d = S_LIM_DN;
          cnt_d   = dur_m1;
        end
      end
      S_LIM_DN: begin
        if (cnt_q == '0) begin
          state_d = S_BIAS_DN;
          cnt_d   = dur_m1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BIAS_DN: begin
        if (cnt_q == '0) begin
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Enables are a pure function of the next state, which keeps out->lim->bias ordering.
  always_comb begin
    bias_d = (state_d != S_OFF);
    lim_d  = (state_d == S_LIM_UP) || (state_d == S_ON) || (state_d == S_LIM_DN);
    out_d  = (state_d == S_ON);
    done_d = ((state_q == S_LIM_UP)  && (state_d == S_ON)) ||
             ((state_q == S_BIAS_DN) && (state_d == S_OFF));
  end

  // CPU port: ready is valid delayed one cycle, no backpressure; every valid cycle is
  // one complete access. rdata carries read data only in the ready cycle of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      rdata    <= '0;
      settle_q <= CNT_W'(16);
    end else begin
      ready <= valid;
      rdata <= '0;
      if (valid) begin
        if (wstrb) begin
          if (!address) settle_q <= wdata[CNT_W-1:0];
        end else begin
          rdata <= address ? DATA_W'(status) : DATA_W'(settle_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_limiter_pwr_seq.sv
// Bench for limiter_pwr_seq: directed vector table, hand-written corner sequences,
// then random stimulus against a stage/elapsed-time reference model.
module tb_limiter_pwr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid, address, wstrb, pd_req;
  logic [31:0] wdata, rdata;
  logic        ready, bias_en, lim_en, out_en, done;
  logic [2:0]  dbg_state;
  logic [4:0]  outs;

  int errors = 0;
  int checks = 0;

  limiter_pwr_seq #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .pd_req(pd_req),
    .bias_en(bias_en), .lim_en(lim_en), .out_en(out_en), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign outs = {bias_en, lim_en, out_en, done, ready};

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic pd, input logic v, input logic w, input logic a,
                        input logic [31:0] d);
    pd_req = pd; valid = v; wstrb = w; address = a; wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  int          m_stage, m_el, m_dur, m_settle;
  logic [4:0]  e_outs;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] m_status(input int st);
    logic b, l, o, busy;
    b = (st != 0); l = (st == 2 || st == 3 || st == 4); o = (st == 3);
    busy = (st != 0 && st != 3);
    return {25'd0, 3'(st), busy, o, l, b};
  endfunction

  task automatic m_enter(input int st);
    m_stage = st;
    m_el    = 1;
    m_dur   = (m_settle == 0) ? 1 : m_settle;
  endtask

  task automatic model_reset();
    m_stage = 0; m_el = 0; m_dur = 1; m_settle = 16;
    exp_q.delete();
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic model_step();
    logic e_done, stage_over;
    e_done = 1'b0;
    stage_over = (m_el >= m_dur);
    if (valid && !wstrb) exp_q.push_back(address ? m_status(m_stage) : m_settle);
    case (m_stage)
      0: if (!pd_req) m_enter(1);
      1: if (pd_req) m_enter(5); else if (stage_over) m_enter(2); else m_el++;
      2: if (pd_req) m_enter(4);
         else if (stage_over) begin m_stage = 3; e_done = 1'b1; end
         else m_el++;
      3: if (pd_req) m_enter(4);
      4: if (stage_over) m_enter(5); else m_el++;
      5: if (stage_over) begin m_stage = 0; e_done = 1'b1; end else m_el++;
      default: m_stage = 0;
    endcase
    if (valid && wstrb && !address) m_settle = int'(wdata[15:0]);
    e_outs = {m_stage != 0, (m_stage == 2 || m_stage == 3 || m_stage == 4),
              m_stage == 3, e_done, valid};
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        pd, v, w, a;
    logic [31:0] d;
    logic [4:0]  exp_o;   // {bias_en, lim_en, out_en, done, ready}
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic pd, input logic v, input logic w, input logic a,
                              input logic [31:0] d, input logic [4:0] eo,
                              input logic cr, input logic [31:0] er);
    vec_t r;
    r.pd = pd; r.v = v; r.w = w; r.a = a; r.d = d;
    r.exp_o = eo; r.chk_rd = cr; r.exp_rd = er;
    return r;
  endfunction

  initial begin
    logic rd_last;
    tbl[0]  = mk(1, 1, 1, 0, 32'd4,  5'b00001, 0, 32'h0);
    tbl[1]  = mk(1, 1, 0, 0, 32'd0,  5'b00001, 1, 32'd4);
    tbl[2]  = mk(0, 0, 0, 0, 32'd0,  5'b10000, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 1, 32'd0,  5'b10001, 1, 32'h19);
    tbl[4]  = mk(0, 1, 1, 1, 32'hff, 5'b10001, 0, 32'h0);
    tbl[5]  = mk(0, 1, 0, 1, 32'd0,  5'b10001, 1, 32'h19);
    tbl[6]  = mk(0, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[8]  = mk(0, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[10] = mk(0, 0, 0, 0, 32'd0,  5'b11110, 0, 32'h0);
    tbl[11] = mk(0, 1, 0, 1, 32'd0,  5'b11101, 1, 32'h37);
    tbl[12] = mk(1, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[13] = mk(1, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[14] = mk(1, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[15] = mk(1, 0, 0, 0, 32'd0,  5'b11000, 0, 32'h0);
    tbl[16] = mk(1, 0, 0, 0, 32'd0,  5'b10000, 0, 32'h0);
    tbl[17] = mk(1, 0, 0, 0, 32'd0,  5'b10000, 0, 32'h0);
    tbl[18] = mk(1, 0, 0, 0, 32'd0,  5'b10000, 0, 32'h0);
    tbl[19] = mk(1, 0, 0, 0, 32'd0,  5'b10000, 0, 32'h0);
    tbl[20] = mk(1, 0, 0, 0, 32'd0,  5'b00010, 0, 32'h0);
    tbl[21] = mk(1, 1, 0, 1, 32'd0,  5'b00001, 1, 32'h0);

    // ---------------- clock/reset ----------------
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SETTLE=4 power-up, STATUS reads, ignored STATUS write, power-down.
    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].pd, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
      tick();
      check($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp_o));
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
    end

    // SETTLE=0: one cycle per stage.
    set_in(1, 1, 1, 0, 32'd0); tick(); check("s0_wr", 32'(outs), 32'b00001);
    set_in(0, 0, 0, 0, 32'd0);
    tick(); check("s0_bias", 32'(outs), 32'b10000);
    tick(); check("s0_lim", 32'(outs), 32'b11000);
    tick(); check("s0_on", 32'(outs), 32'b11110);
    set_in(1, 0, 0, 0, 32'd0);
    tick(); check("s0_limdn", 32'(outs), 32'b11000);
    tick(); check("s0_biasdn", 32'(outs), 32'b10000);
    tick(); check("s0_off", 32'(outs), 32'b00010);

    // SETTLE=8, abort three cycles into LIM_UP.
    set_in(1, 1, 1, 0, 32'd8); tick(); check("s8_wr", 32'(outs), 32'b00001);
    set_in(0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 8; i++) begin tick(); check("s8_biasup", 32'(outs), 32'b10000); end
    for (int i = 0; i < 3; i++) begin tick(); check("s8_limup", 32'(outs), 32'b11000); end
    set_in(1, 0, 0, 0, 32'd0);
    for (int i = 0; i < 8; i++) begin tick(); check("s8_limdn", 32'(outs), 32'b11000); end
    for (int i = 0; i < 8; i++) begin tick(); check("s8_biasdn", 32'(outs), 32'b10000); end
    tick(); check("s8_off", 32'(outs), 32'b00010);
    check("s8_state", 32'(dbg_state), 32'd0);

    // Asynchronous reset while ON drops enables without a clock edge.
    set_in(1, 1, 1, 0, 32'd1); tick();
    set_in(0, 0, 0, 0, 32'd0);
    repeat (3) tick();
    check("ar_on", 32'(outs), 32'b11110);
    #2 rst_n = 1'b0;
    #1;
    check("ar_enables", 32'({bias_en, lim_en, out_en}), 32'h0);
    check("ar_state", 32'(dbg_state), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 1, 0, 0, 32'd0);
    tick();
    check("ar_settle", rdata, 32'd16);
    check("ar_outs", 32'(outs), 32'b00001);

    // ---------------- random stimulus with scoreboard ----------------
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic pd_n;
      pd_n = ($urandom_range(0, 15) == 0) ? ~pd_req : pd_req;
      set_in(pd_n, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), {16'($urandom), 16'($urandom_range(0, 6))});
      rd_last = valid && !wstrb;
      model_step();
      tick();
      check("rnd_outs", 32'(outs), 32'(e_outs));
      check("rnd_state", 32'(dbg_state), 32'(m_stage));
      check("rnd_order", 32'((out_en & ~lim_en) | (lim_en & ~bias_en)), 32'h0);
      if (rd_last) begin
        if (exp_q.size() == 0) check("rnd_rd_queue", 32'h0, 32'h1);
        else check("rnd_rdata", rdata, exp_q.pop_front());
      end
    end
    check("rnd_queue_empty", 32'(exp_q.size()), 32'h0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
